recover_sequencer: RTL and testbench
====================================

RECOVER_SEQUENCER -- requirements
Module: recover_sequencer

Interface
REQ-001 SHALL have parameter QDEPTH, default 8, meaning recovery-request queue entries (power of 2, min 2).
REQ-002 SHALL have port clk  input  1  the single clock.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port fetchwavedecode_recover_en  input  1  page-fault recovery request strobe, one cycle per request.
REQ-005 SHALL have port fetchwavedecode_recover_wfid  input  `WF_ID_LENGTH  wavefront to recover.
REQ-006 SHALL have port fetch_recover_pc  input  32  PC of that wavefront's idempotent barrier.
REQ-007 SHALL have port wave_flush_en  output  1  flush request to wavepool for wave_flush_wfid.
REQ-008 SHALL have port wave_flush_wfid  output  `WF_ID_LENGTH  wavefront being flushed.
REQ-009 SHALL have port wave_flush_done  input  1  wavepool flush complete, one-cycle pulse.
REQ-010 SHALL have port fetch_redirect_valid  output  1  PC override request to fetch.
REQ-011 SHALL have port fetch_redirect_wfid  output  `WF_ID_LENGTH  wavefront being redirected.
REQ-012 SHALL have port fetch_redirect_pc  output  32  restart PC.
REQ-013 SHALL have port fetch_redirect_ack  input  1  fetch accepted redirect, one-cycle pulse.
REQ-014 SHALL have port recover_pending_arry  output  `WF_PER_CU  one bit per wavefront queued or in service; issue holds these wavefronts.
REQ-015 SHALL have port queue_overflow  output  1  sticky flag, request dropped because queue full.

Function
REQ-016 Enqueue: recover_en high, wfid's pending bit clear, queue not full -> write {wfid, pc} at tail, set pending bit at clock edge.
REQ-017 Duplicate: recover_en high with wfid pending -> request dropped, no state change, no overflow.
REQ-018 Full: recover_en high, non-duplicate, queue full -> request dropped, queue_overflow set, remains set until reset.
REQ-019 FSM states IDLE, FLUSH, REDIRECT; one wavefront serviced at a time, FIFO order.
REQ-020 IDLE: queue non-empty -> pop head into service registers, go FLUSH; else stay.
REQ-021 FLUSH: wave_flush_en=1, wave_flush_wfid=service wfid, held until wave_flush_done; on done -> REDIRECT next cycle.
REQ-022 REDIRECT: fetch_redirect_valid=1 with service wfid/pc, held stable until fetch_redirect_ack; on ack -> clear that pending bit, go IDLE.
REQ-023 wave_flush_en and fetch_redirect_valid SHALL be decoded from registered state only; never both high.
REQ-024 Latency: request at cycle N into empty queue with FSM IDLE -> wave_flush_en high at N+2; ack at cycle M -> pending bit low at M+1.
REQ-025 Simultaneous enqueue and pop SHALL both succeed; count unchanged; full-check uses pre-pop count.
REQ-026 Request whose wfid's pending bit clears in the same cycle (REDIRECT ack) SHALL be accepted as a new request.
REQ-027 wave_flush_done outside FLUSH and fetch_redirect_ack outside REDIRECT SHALL be ignored.
REQ-028 Pointers wrap modulo QDEPTH; count is log2(QDEPTH)+1 bits.

Reset
REQ-029 On rst: state IDLE, queue empty, pointers/count 0, recover_pending_arry 0, queue_overflow 0, all outputs 0.
REQ-030 Reset mid-operation SHALL abandon in-service and queued requests; no flush/redirect after reset release without new request.

Structure
REQ-031 `WF_PER_CU and `WF_ID_LENGTH from the shared global defines; FSM state encodings in the same shared header.
REQ-032 Queue as one sub-module, recover_fifo (QDEPTH x (`WF_ID_LENGTH+32)), built from dff cells; FSM and pending vector in top.

Verification
REQ-033 Single: req wfid=5 pc=0x100 -> flush_en wfid 5 at N+2; done -> redirect valid pc 0x100; ack -> pending[5]=0, IDLE.
REQ-034 Duplicate: wfid 7 twice while pending -> exactly one flush and one redirect for wfid 7, overflow 0.
REQ-035 Overflow: QDEPTH=8, FSM stalled (no done), 10 distinct wfids -> 1 in service + 8 queued, 1 dropped, queue_overflow=1.
REQ-036 Order/backpressure: wfids 3,9,12 queued; ack delayed 5 cycles -> redirect pc stable during delay, service order 3,9,12.
REQ-037 Same-cycle re-fault: wfid 4 request coincident with its ack -> second flush for wfid 4 follows.
REQ-038 Reset in FLUSH with 3 queued -> all outputs 0 next cycle, no activity after release.

Source files
------------

// File: rtl/recover_sequencer_pkg.sv
// rtl/recover_sequencer_pkg.sv - shared wavefront sizing, FSM encodings and queue entry type
//
// WF_PER_CU     : wavefronts per compute unit (width of the pending vector)
// WF_ID_LENGTH  : bits in a wavefront id
// ST_*          : recovery FSM state encodings
// recover_entry_t : one queued recovery request {wfid, pc}

package recover_sequencer_pkg;

    localparam int WF_PER_CU    = 40;
    localparam int WF_ID_LENGTH = 6;
    localparam int PC_WIDTH     = 32;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_FLUSH    = 2'd1;
    localparam logic [1:0] ST_REDIRECT = 2'd2;

    typedef struct packed {
        logic [WF_ID_LENGTH-1:0] wfid;
        logic [PC_WIDTH-1:0]     pc;
    } recover_entry_t;

endpackage

// File: rtl/recover_sequencer_fifo.sv
// rtl/recover_sequencer_fifo.sv - recovery-request queue built from enable flops
//
// recover_dff  : WIDTH-bit flop with load enable, async active-high reset
// recover_fifo : QDEPTH x WIDTH queue
//   clk, rst : clock, async active-high reset
//   push     : write wdata at tail (ignored when full)
//   pop      : advance head (ignored when empty)
//   wdata    : entry to write
//   rdata    : current head entry
//   empty    : no entries held
//   full     : QDEPTH entries held (before any same-cycle pop)

module recover_dff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

module recover_fifo #(
    parameter int QDEPTH = 8,
    parameter int WIDTH  = 38
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(QDEPTH);

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             push_ok;
    logic             pop_ok;
    logic [WIDTH-1:0] mem [QDEPTH];

    assign empty   = (cnt == '0);
    assign full    = (cnt == (AW+1)'(QDEPTH));
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    for (genvar i = 0; i < QDEPTH; i++) begin : g_entry
        recover_dff #(.WIDTH(WIDTH)) u_entry (
            .clk (clk),
            .rst (rst),
            .en  (push_ok && (wr_ptr == AW'(i))),
            .d   (wdata),
            .q   (mem[i])
        );
    end

    // QDEPTH is a power of two, so plain increment wraps the pointers.
    recover_dff #(.WIDTH(AW)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .en  (push_ok),
        .d   (wr_ptr + 1'b1),
        .q   (wr_ptr)
    );

    recover_dff #(.WIDTH(AW)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .en  (pop_ok),
        .d   (rd_ptr + 1'b1),
        .q   (rd_ptr)
    );

    // Count only moves when exactly one of push/pop happens.
    recover_dff #(.WIDTH(AW+1)) u_cnt (
        .clk (clk),
        .rst (rst),
        .en  (push_ok ^ pop_ok),
        .d   (push_ok ? cnt + 1'b1 : cnt - 1'b1),
        .q   (cnt)
    );

endmodule

// File: rtl/recover_sequencer.sv
// rtl/recover_sequencer.sv - page-fault recovery sequencer: queue, flush, then redirect fetch
//
// clk, rst                     : clock, async active-high reset
// fetchwavedecode_recover_en   : recovery request strobe
// fetchwavedecode_recover_wfid : wavefront to recover
// fetch_recover_pc             : restart PC for that wavefront
// wave_flush_en / _wfid        : flush request to wavepool, held until wave_flush_done
// wave_flush_done              : wavepool flush complete pulse
// fetch_redirect_valid/_wfid/_pc : PC override to fetch, held until fetch_redirect_ack
// fetch_redirect_ack           : fetch accepted redirect pulse
// recover_pending_arry         : wavefronts queued or in service
// queue_overflow               : sticky, a request was dropped on a full queue

module recover_sequencer
    import recover_sequencer_pkg::*;
#(
    parameter int QDEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    fetchwavedecode_recover_en,
    input  logic [WF_ID_LENGTH-1:0] fetchwavedecode_recover_wfid,
    input  logic [31:0]             fetch_recover_pc,
    output logic                    wave_flush_en,
    output logic [WF_ID_LENGTH-1:0] wave_flush_wfid,
    input  logic                    wave_flush_done,
    output logic                    fetch_redirect_valid,
    output logic [WF_ID_LENGTH-1:0] fetch_redirect_wfid,
    output logic [31:0]             fetch_redirect_pc,
    input  logic                    fetch_redirect_ack,
    output logic [WF_PER_CU-1:0]    recover_pending_arry,
    output logic                    queue_overflow
);

    localparam logic [WF_ID_LENGTH:0] WF_LIMIT = (WF_ID_LENGTH+1)'(WF_PER_CU);

    logic [1:0]              state;
    logic [WF_ID_LENGTH-1:0] svc_wfid;
    logic [31:0]             svc_pc;
    logic [WF_PER_CU-1:0]    pending_next;
    recover_entry_t          head;
    recover_entry_t          req_entry;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic                    wfid_ok;
    logic                    clear_now;
    logic                    req_pending;
    logic                    req_valid;
    logic                    push;
    logic                    pop;

    assign req_entry = '{wfid: fetchwavedecode_recover_wfid, pc: fetch_recover_pc};

    // Ids beyond the wavefront count have no pending bit and are dropped.
    assign wfid_ok   = ({1'b0, fetchwavedecode_recover_wfid} < WF_LIMIT);
    assign clear_now = (state == ST_REDIRECT) && fetch_redirect_ack;

    // A wavefront finishing service this cycle may immediately re-fault.
    assign req_pending = recover_pending_arry[fetchwavedecode_recover_wfid]
                         && !(clear_now && (svc_wfid == fetchwavedecode_recover_wfid));
    assign req_valid   = fetchwavedecode_recover_en && wfid_ok && !req_pending;
    assign push        = req_valid && !fifo_full;
    assign pop         = (state == ST_IDLE) && !fifo_empty;

    recover_fifo #(
        .QDEPTH (QDEPTH),
        .WIDTH  (WF_ID_LENGTH + PC_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (req_entry),
        .rdata (head),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            svc_wfid <= '0;
            svc_pc   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        svc_wfid <= head.wfid;
                        svc_pc   <= head.pc;
                        state    <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (wave_flush_done) begin
                        state <= ST_REDIRECT;
                    end
                end
                ST_REDIRECT: begin
                    if (fetch_redirect_ack) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Set after clear so a same-cycle re-fault leaves the bit pending.
    always_comb begin
        pending_next = recover_pending_arry;
        if (clear_now) begin
            pending_next[svc_wfid] = 1'b0;
        end
        if (push) begin
            pending_next[fetchwavedecode_recover_wfid] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            recover_pending_arry <= '0;
            queue_overflow       <= 1'b0;
        end else begin
            recover_pending_arry <= pending_next;
            if (req_valid && fifo_full) begin
                queue_overflow <= 1'b1;
            end
        end
    end

    assign wave_flush_en        = (state == ST_FLUSH);
    assign wave_flush_wfid      = wave_flush_en ? svc_wfid : '0;
    assign fetch_redirect_valid = (state == ST_REDIRECT);
    assign fetch_redirect_wfid  = fetch_redirect_valid ? svc_wfid : '0;
    assign fetch_redirect_pc    = fetch_redirect_valid ? svc_pc : '0;

endmodule

// File: tb/tb_recover_sequencer.sv
// tb/tb_recover_sequencer.sv - self-checking bench for recover_sequencer

module tb_recover_sequencer;
    import recover_sequencer_pkg::*;

    localparam int QDEPTH = 8;

    logic                    clk;
    logic                    rst;
    logic                    recover_en;
    logic [WF_ID_LENGTH-1:0] recover_wfid;
    logic [31:0]             recover_pc;
    logic                    wave_flush_en;
    logic [WF_ID_LENGTH-1:0] wave_flush_wfid;
    logic                    wave_flush_done;
    logic                    fetch_redirect_valid;
    logic [WF_ID_LENGTH-1:0] fetch_redirect_wfid;
    logic [31:0]             fetch_redirect_pc;
    logic                    fetch_redirect_ack;
    logic [WF_PER_CU-1:0]    recover_pending_arry;
    logic                    queue_overflow;

    recover_sequencer #(.QDEPTH(QDEPTH)) dut (
        .clk                          (clk),
        .rst                          (rst),
        .fetchwavedecode_recover_en   (recover_en),
        .fetchwavedecode_recover_wfid (recover_wfid),
        .fetch_recover_pc             (recover_pc),
        .wave_flush_en                (wave_flush_en),
        .wave_flush_wfid              (wave_flush_wfid),
        .wave_flush_done              (wave_flush_done),
        .fetch_redirect_valid         (fetch_redirect_valid),
        .fetch_redirect_wfid          (fetch_redirect_wfid),
        .fetch_redirect_pc            (fetch_redirect_pc),
        .fetch_redirect_ack           (fetch_redirect_ack),
        .recover_pending_arry         (recover_pending_arry),
        .queue_overflow               (queue_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: a list of waiting requests, a set of pending ids, and
    // which phase (none / flushing / redirecting) the serviced wavefront is in.
    typedef struct {
        int          wfid;
        int unsigned pc;
    } ent_t;

    ent_t                 mq[$];
    bit [WF_PER_CU-1:0]   mpend;
    bit                   movf;
    int                   mphase;     // 0 none, 1 flushing, 2 redirecting
    int                   msvc_wfid;
    int unsigned          msvc_pc;

    task automatic model_clear();
        mq.delete();
        mpend     = '0;
        movf      = 1'b0;
        mphase    = 0;
        msvc_wfid = 0;
        msvc_pc   = 0;
    endtask

    task automatic check_model();
        chk("flush_en",     64'(wave_flush_en),        64'(mphase == 1));
        chk("flush_wfid",   64'(wave_flush_wfid),      (mphase == 1) ? 64'(msvc_wfid) : 64'd0);
        chk("redir_valid",  64'(fetch_redirect_valid), 64'(mphase == 2));
        chk("redir_wfid",   64'(fetch_redirect_wfid),  (mphase == 2) ? 64'(msvc_wfid) : 64'd0);
        chk("redir_pc",     64'(fetch_redirect_pc),    (mphase == 2) ? 64'(msvc_pc) : 64'd0);
        chk("pending",      64'(recover_pending_arry), 64'(mpend));
        chk("overflow",     64'(queue_overflow),       64'(movf));
    endtask

    // One clock: drive inputs, advance the model, then compare after the edge.
    task automatic step(input bit en, input int wfid, input int unsigned pc,
                        input bit done, input bit ack);
        bit   finishing;
        bit   dup;
        bit   is_full;
        ent_t e;
        recover_en         = en;
        recover_wfid       = WF_ID_LENGTH'(wfid);
        recover_pc         = pc;
        wave_flush_done    = done;
        fetch_redirect_ack = ack;

        finishing = (mphase == 2) && ack;
        dup       = mpend[wfid] && !(finishing && msvc_wfid == wfid);
        is_full   = (mq.size() >= QDEPTH);
        if (en && !dup && is_full) movf = 1'b1;
        if (mphase == 0 && mq.size() > 0) begin
            e         = mq.pop_front();
            msvc_wfid = e.wfid;
            msvc_pc   = e.pc;
            mphase    = 1;
        end else if (mphase == 1 && done) begin
            mphase = 2;
        end else if (finishing) begin
            mphase           = 0;
            mpend[msvc_wfid] = 1'b0;
        end
        if (en && !dup && !is_full) begin
            mq.push_back('{wfid, pc});
            mpend[wfid] = 1'b1;
        end

        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic idle();
        step(1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    // Reset asserted mid-cycle; outputs must clear at once and stay clear.
    task automatic do_reset();
        recover_en         = 1'b0;
        wave_flush_done    = 1'b0;
        fetch_redirect_ack = 1'b0;
        rst = 1'b1;
        #2;
        chk("rst_flush_async", 64'(wave_flush_en), 64'd0);
        @(posedge clk);
        #1;
        chk("rst_flush",    64'(wave_flush_en),        64'd0);
        chk("rst_redir",    64'(fetch_redirect_valid), 64'd0);
        chk("rst_redir_pc", 64'(fetch_redirect_pc),    64'd0);
        chk("rst_pending",  64'(recover_pending_arry), 64'd0);
        chk("rst_overflow", 64'(queue_overflow),       64'd0);
        rst = 1'b0;
        model_clear();
    endtask

    typedef struct {
        bit          en;
        int          wfid;
        int unsigned pc;
        bit          done;
        bit          ack;
        bit          e_flush;
        int          e_fwfid;
        bit          e_redir;
        int unsigned e_rpc;
        bit          e_pend;
    } vec_t;

    vec_t tbl[$];
    int   order[$];

    initial begin
        rst                = 1'b1;
        recover_en         = 1'b0;
        recover_wfid       = '0;
        recover_pc         = '0;
        wave_flush_done    = 1'b0;
        fetch_redirect_ack = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_model();
        rst = 1'b0;

        // single request wfid 5
        tbl.push_back('{1, 5, 32'h100, 0, 0,  0, 0, 0, 0,      1});
        tbl.push_back('{0, 5, 0,       0, 0,  1, 5, 0, 0,      1});
        tbl.push_back('{0, 5, 0,       1, 0,  0, 0, 1, 32'h100, 1});
        tbl.push_back('{0, 5, 0,       0, 0,  0, 0, 1, 32'h100, 1});
        tbl.push_back('{0, 5, 0,       0, 1,  0, 0, 0, 0,      0});
        tbl.push_back('{0, 5, 0,       0, 0,  0, 0, 0, 0,      0});
        // duplicate requests for wfid 7
        tbl.push_back('{1, 7, 32'h200, 0, 0,  0, 0, 0, 0,      1});
        tbl.push_back('{1, 7, 32'h204, 0, 0,  1, 7, 0, 0,      1});
        tbl.push_back('{1, 7, 32'h208, 0, 0,  1, 7, 0, 0,      1});
        tbl.push_back('{0, 7, 0,       1, 0,  0, 0, 1, 32'h200, 1});
        tbl.push_back('{1, 7, 32'h20c, 0, 0,  0, 0, 1, 32'h200, 1});
        tbl.push_back('{0, 7, 0,       0, 1,  0, 0, 0, 0,      0});
        tbl.push_back('{0, 7, 0,       0, 0,  0, 0, 0, 0,      0});
        tbl.push_back('{0, 7, 0,       0, 0,  0, 0, 0, 0,      0});
        // done/ack outside their phases, then same-cycle re-fault of wfid 4
        tbl.push_back('{0, 4, 0,       1, 1,  0, 0, 0, 0,      0});
        tbl.push_back('{1, 4, 32'h300, 0, 1,  0, 0, 0, 0,      1});
        tbl.push_back('{0, 4, 0,       0, 1,  1, 4, 0, 0,      1});
        tbl.push_back('{0, 4, 0,       1, 0,  0, 0, 1, 32'h300, 1});
        tbl.push_back('{1, 4, 32'h340, 0, 1,  0, 0, 0, 0,      1});
        tbl.push_back('{0, 4, 0,       0, 0,  1, 4, 0, 0,      1});
        tbl.push_back('{0, 4, 0,       1, 0,  0, 0, 1, 32'h340, 1});
        tbl.push_back('{0, 4, 0,       0, 1,  0, 0, 0, 0,      0});
        tbl.push_back('{0, 4, 0,       0, 0,  0, 0, 0, 0,      0});

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].en, tbl[i].wfid, tbl[i].pc, tbl[i].done, tbl[i].ack);
            chk($sformatf("tbl%0d_flush", i),   64'(wave_flush_en),        64'(tbl[i].e_flush));
            chk($sformatf("tbl%0d_fwfid", i),   64'(wave_flush_wfid),      64'(tbl[i].e_fwfid));
            chk($sformatf("tbl%0d_redir", i),   64'(fetch_redirect_valid), 64'(tbl[i].e_redir));
            chk($sformatf("tbl%0d_rpc", i),     64'(fetch_redirect_pc),    64'(tbl[i].e_rpc));
            chk($sformatf("tbl%0d_pend", i),    64'(recover_pending_arry[tbl[i].wfid]), 64'(tbl[i].e_pend));
            chk($sformatf("tbl%0d_ovf", i),     64'(queue_overflow),       64'd0);
        end

        // overflow: stalled in flush, 10 distinct wfids
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b1, 20 + i, 32'h4000 + 4 * i, 1'b0, 1'b0);
        chk("ovf_flag",    64'(queue_overflow),                  64'd1);
        chk("ovf_pending", 64'($countones(recover_pending_arry)), 64'd9);
        chk("ovf_dropped", 64'(recover_pending_arry[29]),        64'd0);
        chk("ovf_service", 64'(wave_flush_wfid),                 64'd20);
        repeat (3) idle();
        chk("ovf_sticky",  64'(queue_overflow),                  64'd1);

        // FIFO order with a slow ack
        do_reset();
        step(1'b1, 3,  32'h1030, 1'b0, 1'b0);
        step(1'b1, 9,  32'h1090, 1'b0, 1'b0);
        step(1'b1, 12, 32'h10c0, 1'b0, 1'b0);
        order.delete();
        for (int k = 0; k < 3; k++) begin
            int          n;
            int unsigned pc0;
            n = 0;
            while (!wave_flush_en && n < 10) begin
                idle();
                n++;
            end
            chk("order_wait_flush", 64'(n < 10), 64'd1);
            order.push_back(int'(wave_flush_wfid));
            step(1'b0, 0, 0, 1'b1, 1'b0);
            pc0 = fetch_redirect_pc;
            chk("order_pc", 64'(pc0), 64'(32'h1000 + 16 * order[k]));
            repeat (5) begin
                idle();
                chk("order_pc_stable", 64'(fetch_redirect_pc),    64'(pc0));
                chk("order_hold",      64'(fetch_redirect_valid), 64'd1);
            end
            step(1'b0, 0, 0, 1'b0, 1'b1);
        end
        chk("order_0", 64'(order[0]), 64'd3);
        chk("order_1", 64'(order[1]), 64'd9);
        chk("order_2", 64'(order[2]), 64'd12);

        // reset in FLUSH with three queued
        do_reset();
        step(1'b1, 1, 32'h10, 1'b0, 1'b0);
        step(1'b1, 2, 32'h20, 1'b0, 1'b0);
        step(1'b1, 3, 32'h30, 1'b0, 1'b0);
        step(1'b1, 6, 32'h60, 1'b0, 1'b0);
        chk("pre_rst_flush", 64'(wave_flush_en),                   64'd1);
        chk("pre_rst_pend",  64'($countones(recover_pending_arry)), 64'd4);
        do_reset();
        begin
            int activity;
            activity = 0;
            repeat (20) begin
                step(1'b0, 0, 0, 1'b1, 1'b1);
                if (wave_flush_en || fetch_redirect_valid) activity++;
            end
            chk("post_rst_activity", 64'(activity), 64'd0);
        end

        // random traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 2) == 0, $urandom_range(0, 11), $urandom,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

endmodule
